fetch_stream_buffer: RTL and testbench
======================================

// Module: fetch_stream_buffer
// PURPOSE
//  Parametrised instruction-fetch front end: issues line-aligned burst reads on the system bus, packs returned beats
//  into a circular byte buffer, and presents a MAX_INST-byte decode window with its RIP to the decoder.
//  Adds byte-granular entry skip, correct per-line RIP advance, and a redirect/flush with stale-burst discard.
//  Sits between the Sysbus master port and the decoder in the core.
// PARAMETERS
//  BUF_BYTES    128  buffer capacity; power of two, >= 2*LINE_BYTES
//  LINE_BYTES   64   bytes per bus burst; power of two, multiple of BEAT_BYTES
//  BEAT_BYTES   8    bytes per response beat
//  MAX_INST     15   decode window bytes; <= BUF_BYTES
// PORTS
//  clk             in   1                 clock; all logic on rising edge
//  reset           in   1                 synchronous, active-low reset (reset==0 resets)
//  entry           in   64                start RIP, sampled while reset==0
//  redirect_valid  in   1                 flush buffer, restart fetch at redirect_rip
//  redirect_rip    in   64                new fetch RIP
//  req_cyc         out  1                 bus read request
//  req_addr        out  64                line-aligned request address
//  req_ack         in   1                 bus accepted request
//  resp_cyc        in   1                 response beat valid
//  resp_data       in   BEAT_BYTES*8      beat; byte k in bits [8k+7:8k]
//  resp_ack        out  1                 = resp_cyc (always accepts)
//  dec_valid       out  1                 window holds MAX_INST valid bytes
//  dec_bytes       out  MAX_INST*8        window; byte at dec_rip+k in bits [8k+7:8k]
//  dec_rip         out  64                RIP of dec_bytes[7:0]
//  dec_consume     in   $clog2(MAX_INST+1) bytes retired this cycle (0..MAX_INST)
//  occupancy       out  $clog2(BUF_BYTES)+1 valid bytes held
// BEHAVIOUR
//  Reset (reset==0): state IDLE, req_cyc=0, req_addr=0, rd/wr ptr=0, occupancy=0, dec_valid=0, stale=0,
//   dec_rip=entry, line_addr=entry & ~(LINE_BYTES-1), skip=entry[log2(LINE_BYTES)-1:0]. Beats during reset ignored.
//  FSM: IDLE -> REQ when occupancy <= BUF_BYTES-LINE_BYTES (whole line fits). REQ: req_cyc=1, req_addr=line_addr,
//   both held stable until req_ack; on req_ack -> WAIT, req_cyc=0 next cycle. WAIT -> ACTIVE on first resp_cyc.
//   Beat counter counts LINE_BYTES/BEAT_BYTES beats; last beat -> IDLE, line_addr += LINE_BYTES, skip=0.
//  Beat write: beat i covers line bytes [i*BEAT, i*BEAT+BEAT-1]; bytes below skip discarded, rest written at wr_ptr
//   in order; wr_ptr/occupancy advance by bytes written. Pointers wrap modulo BUF_BYTES.
//  Beat written at edge t is visible on dec_bytes/occupancy after edge t (1-cycle latency).
//  dec_valid = occupancy >= MAX_INST (combinational from registers). dec_bytes read from rd_ptr with wrap.
//  dec_consume sampled only when dec_valid; rd_ptr += n, dec_rip += n. Ignored when !dec_valid.
//  Same-cycle write and consume: occupancy_next = occupancy + written - consumed.
//  Redirect (highest priority, dec_consume and same-cycle beat ignored): rd=wr=0, occupancy=0,
//   dec_rip=redirect_rip, line_addr=redirect_rip & ~(LINE_BYTES-1), skip=low bits of redirect_rip.
//   IDLE: stays IDLE. REQ: request kept on bus until ack (protocol), stale=1. WAIT/ACTIVE: stale=1.
//   While stale, all beats of that burst are acked and discarded, no line_addr advance; burst end -> IDLE, stale=0.
//   Redirect during a stale burst only updates targets; stale stays 1.
//  Only one request outstanding at any time. resp_cyc in IDLE/REQ is a protocol error (assert).
//  Decoder must not consume beyond the program end; tail < MAX_INST bytes is never presented.
// TESTING
//  entry=0x1000, release reset -> REQ req_addr=0x1000; 8 beats -> occupancy=64, dec_valid=1, dec_rip=0x1000, dec_bytes=bytes 0..14.
//  entry=0x1005 -> beat0 writes 3 bytes; after burst occupancy=59, dec_rip=0x1005, dec_bytes[7:0]=line byte 5.
//  No consume: two lines -> occupancy=128, no third req_cyc; consume 15 x5 -> occupancy=53 -> REQ at 0x1080.
//  Consume to rd_ptr=120 with occupancy>=15 -> dec_bytes = buffer bytes 120..127,0..6 (wrap correct).
//  Redirect to 0x2010 during ACTIVE beat 3 -> beats 4..7 acked, occupancy stays 0; then req_addr=0x2000,
//   after burst occupancy=48, dec_rip=0x2010.
//  Reset low mid-ACTIVE -> next edge req_cyc=0, occupancy=0, dec_valid=0, dec_rip=entry; restart clean.

Source files
------------

// File: rtl/fetch_stream_buffer.sv
// Instruction-fetch stream buffer: issues line-aligned burst reads, packs the
// returned beats into a circular byte buffer and presents a MAX_INST-byte
// decode window at dec_rip. Supports entry/redirect byte skip and discards
// beats of a burst that was in flight when a redirect arrived.
module fetch_stream_buffer #(
  parameter int BUF_BYTES  = 128,
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_INST   = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [63:0]                     entry,
  input  logic                            redirect_valid,
  input  logic [63:0]                     redirect_rip,
  output logic                            req_cyc,
  output logic [63:0]                     req_addr,
  input  logic                            req_ack,
  input  logic                            resp_cyc,
  input  logic [BEAT_BYTES*8-1:0]         resp_data,
  output logic                            resp_ack,
  output logic                            dec_valid,
  output logic [MAX_INST*8-1:0]           dec_bytes,
  output logic [63:0]                     dec_rip,
  input  logic [$clog2(MAX_INST+1)-1:0]   dec_consume,
  output logic [$clog2(BUF_BYTES):0]      occupancy
);
  localparam int PW     = $clog2(BUF_BYTES);
  localparam int LW     = $clog2(LINE_BYTES);
  localparam int BW     = $clog2(BEAT_BYTES);
  localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int DW     = $clog2(MAX_INST+1);

  localparam logic [PW:0]   OCC_THR   = (PW+1)'(BUF_BYTES - LINE_BYTES);
  localparam logic [PW:0]   OCC_WIN   = (PW+1)'(MAX_INST);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);
  localparam logic [63:0]   LMASK     = ~64'(LINE_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACTIVE} state_t;

  state_t                       r_state;
  logic                         r_req_cyc;
  logic [63:0]                  r_req_addr;
  logic [63:0]                  r_line_addr;
  logic [LW-1:0]                r_skip;
  logic [CW-1:0]                r_beat;
  logic                         r_stale;
  logic [PW-1:0]                r_rd_ptr;
  logic [PW-1:0]                r_wr_ptr;
  logic [PW:0]                  r_occ;
  logic [63:0]                  r_dec_rip;
  logic [7:0]                   r_mem [BUF_BYTES];

  logic                         w_beat;
  logic                         w_do_write;
  logic [BEAT_BYTES-1:0]        w_wr_en;
  logic [BEAT_BYTES-1:0][PW-1:0] w_wr_idx;
  logic [BW:0]                  w_wr_cnt;
  logic [BW:0]                  w_written;
  logic [DW-1:0]                w_consumed;

  assign resp_ack  = resp_cyc;
  assign req_cyc   = r_req_cyc;
  assign req_addr  = r_req_addr;
  assign dec_rip   = r_dec_rip;
  assign occupancy = r_occ;
  assign dec_valid = (r_occ >= OCC_WIN);

  // A beat is only meaningful while a burst is outstanding; redirect and
  // stale bursts drop the data but the beat still counts toward burst end.
  assign w_beat     = resp_cyc && (r_state == S_WAIT || r_state == S_ACTIVE);
  assign w_do_write = w_beat && !r_stale && !redirect_valid;
  assign w_written  = w_do_write ? w_wr_cnt : '0;
  assign w_consumed = (dec_valid && !redirect_valid) ? dec_consume : '0;

  // Pack the beat bytes at or above the skip offset contiguously from wr_ptr
  always_comb begin
    w_wr_en  = '0;
    w_wr_idx = '0;
    w_wr_cnt = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      if ((int'(r_beat) * BEAT_BYTES + k) >= int'(r_skip)) begin
        w_wr_en[k]  = 1'b1;
        w_wr_idx[k] = r_wr_ptr + PW'(w_wr_cnt);
        w_wr_cnt    = w_wr_cnt + (BW+1)'(1);
      end
    end
  end

  // Decode window read from rd_ptr; pointer arithmetic wraps naturally
  always_comb begin
    dec_bytes = '0;
    for (int k = 0; k < MAX_INST; k++)
      dec_bytes[8*k +: 8] = r_mem[r_rd_ptr + PW'(k)];
  end

  // Byte storage; contents are don't-care until covered by occupancy
  always_ff @(posedge clk) begin
    if (reset && w_do_write) begin
      for (int k = 0; k < BEAT_BYTES; k++)
        if (w_wr_en[k]) r_mem[w_wr_idx[k]] <= resp_data[8*k +: 8];
    end
  end

  // Pointer/occupancy bookkeeping and the bus request FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req_cyc   <= 1'b0;
      r_req_addr  <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occ       <= '0;
      r_stale     <= 1'b0;
      r_beat      <= '0;
      r_dec_rip   <= entry;
      r_line_addr <= entry & LMASK;
      r_skip      <= entry[LW-1:0];
    end else begin
      if (redirect_valid) begin
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_occ       <= '0;
        r_dec_rip   <= redirect_rip;
        r_line_addr <= redirect_rip & LMASK;
        r_skip      <= redirect_rip[LW-1:0];
      end else begin
        r_wr_ptr  <= r_wr_ptr + PW'(w_written);
        r_rd_ptr  <= r_rd_ptr + PW'(w_consumed);
        r_occ     <= r_occ + (PW+1)'(w_written) - (PW+1)'(w_consumed);
        r_dec_rip <= r_dec_rip + 64'(w_consumed);
      end

      case (r_state)
        S_IDLE: begin
          // Redirect updates line_addr this edge, so request from next cycle
          if (!redirect_valid && r_occ <= OCC_THR) begin
            r_state    <= S_REQ;
            r_req_cyc  <= 1'b1;
            r_req_addr <= r_line_addr;
          end
        end
        S_REQ: begin
          // Request must stay on the bus until acked even if now stale
          if (redirect_valid) r_stale <= 1'b1;
          if (req_ack) begin
            r_state   <= S_WAIT;
            r_req_cyc <= 1'b0;
            r_beat    <= '0;
          end
        end
        S_WAIT, S_ACTIVE: begin
          if (redirect_valid) r_stale <= 1'b1;
          if (resp_cyc) begin
            if (r_beat == LAST_BEAT) begin
              r_state <= S_IDLE;
              r_stale <= 1'b0;
              r_beat  <= '0;
              if (!r_stale && !redirect_valid) begin
                r_line_addr <= r_line_addr + 64'(LINE_BYTES);
                r_skip      <= '0;
              end
            end else begin
              r_state <= S_ACTIVE;
              r_beat  <= r_beat + CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Beats are only legal while a burst is outstanding
  always_ff @(posedge clk) begin
    if (reset && resp_cyc)
      assert (r_state == S_WAIT || r_state == S_ACTIVE);
  end

endmodule

// File: tb/tb_fetch_stream_buffer.sv
// Directed bench for fetch_stream_buffer: bus responder tasks return bytes
// whose value is a fixed function of their address, so every window can be
// predicted from its RIP alone.
module tb_fetch_stream_buffer;
  localparam int BUF_BYTES = 128, LINE_BYTES = 64, BEAT_BYTES = 8, MAX_INST = 15;
  localparam int NB = LINE_BYTES / BEAT_BYTES;

  logic         clk = 0;
  logic         reset;
  logic [63:0]  entry;
  logic         redirect_valid;
  logic [63:0]  redirect_rip;
  logic         req_cyc;
  logic [63:0]  req_addr;
  logic         req_ack;
  logic         resp_cyc;
  logic [63:0]  resp_data;
  logic         resp_ack;
  logic         dec_valid;
  logic [119:0] dec_bytes;
  logic [63:0]  dec_rip;
  logic [3:0]   dec_consume;
  logic [7:0]   occupancy;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stream_buffer #(.BUF_BYTES(BUF_BYTES), .LINE_BYTES(LINE_BYTES),
                        .BEAT_BYTES(BEAT_BYTES), .MAX_INST(MAX_INST)) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .redirect_valid(redirect_valid), .redirect_rip(redirect_rip),
    .req_cyc(req_cyc), .req_addr(req_addr), .req_ack(req_ack),
    .resp_cyc(resp_cyc), .resp_data(resp_data), .resp_ack(resp_ack),
    .dec_valid(dec_valid), .dec_bytes(dec_bytes), .dec_rip(dec_rip),
    .dec_consume(dec_consume), .occupancy(occupancy));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image: byte at address a
  function automatic logic [7:0] mem_b(input logic [63:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [63:0] beat_of(input logic [63:0] a);
    logic [63:0] b;
    for (int k = 0; k < BEAT_BYTES; k++) b[8*k +: 8] = mem_b(a + 64'(k));
    return b;
  endfunction

  function automatic logic [119:0] win(input logic [63:0] rip);
    logic [119:0] w;
    for (int k = 0; k < MAX_INST; k++) w[8*k +: 8] = mem_b(rip + 64'(k));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req_cyc && n < 100) begin tick(); n++; end
    chk("req_seen", req_cyc, 1);
  endtask

  // Accept the next request, check it, then return one full burst.
  // A redirect to rrip is raised alongside beat rd_beat (-1: none).
  task automatic serve(input logic [63:0] exp_addr, input int rd_beat, input logic [63:0] rrip);
    logic [63:0] a;
    wait_req();
    chk("req_addr", req_addr, exp_addr);
    a = req_addr;
    tick();
    chk("req_hold", {req_cyc, req_addr}, {1'b1, exp_addr});
    req_ack = 1; tick(); req_ack = 0;
    chk("req_drop", req_cyc, 0);
    tick();
    for (int i = 0; i < NB; i++) begin
      resp_cyc       = 1;
      resp_data      = beat_of(a + 64'(i * BEAT_BYTES));
      redirect_valid = (i == rd_beat);
      redirect_rip   = rrip;
      tick();
    end
    resp_cyc = 0; redirect_valid = 0;
  endtask

  task automatic consume(input int n, input int times);
    for (int i = 0; i < times; i++) begin
      dec_consume = 4'(n); tick(); dec_consume = 0;
    end
  endtask

  initial begin
    logic saw;
    reset = 0; entry = 64'h1000; redirect_valid = 0; redirect_rip = 0;
    req_ack = 0; resp_cyc = 0; resp_data = 0; dec_consume = 0;
    tick(); tick(); tick();
    chk("rst_req_cyc", req_cyc, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_rip", dec_rip, 64'h1000);

    // First line from an aligned entry
    reset = 1;
    serve(64'h1000, -1, 0);
    chk("l1_occ", occupancy, 64);
    chk("l1_valid", dec_valid, 1);
    chk("l1_rip", dec_rip, 64'h1000);
    chk("l1_win", dec_bytes, win(64'h1000));

    // Second line fills the buffer; no third request may appear
    serve(64'h1040, -1, 0);
    chk("l2_occ", occupancy, 128);
    saw = 0;
    for (int i = 0; i < 10; i++) begin saw |= req_cyc; tick(); end
    chk("no_req3", saw, 0);

    // Drain 75 bytes, which frees room for the third line
    consume(15, 5);
    chk("c75_occ", occupancy, 53);
    chk("c75_rip", dec_rip, 64'h104B);
    chk("c75_win", dec_bytes, win(64'h104B));
    serve(64'h1080, -1, 0);
    chk("l3_occ", occupancy, 117);

    // rd_ptr reaches 120: window straddles the buffer wrap
    consume(15, 3);
    chk("wrap_occ", occupancy, 72);
    chk("wrap_rip", dec_rip, 64'h1078);
    chk("wrap_win", dec_bytes, win(64'h1078));

    // Unaligned entry: first 5 line bytes skipped
    reset = 0; entry = 64'h1005; tick(); tick();
    reset = 1;
    serve(64'h1000, -1, 0);
    chk("skip_occ", occupancy, 59);
    chk("skip_rip", dec_rip, 64'h1005);
    chk("skip_win", dec_bytes, win(64'h1005));

    // Redirect alongside beat 3: rest of burst is discarded
    reset = 0; entry = 64'h1000; tick(); tick();
    reset = 1;
    serve(64'h1000, 3, 64'h2010);
    chk("rd_occ", occupancy, 0);
    chk("rd_valid", dec_valid, 0);
    consume(5, 1);
    serve(64'h2000, -1, 0);
    chk("rd2_occ", occupancy, 48);
    chk("rd2_rip", dec_rip, 64'h2010);
    chk("rd2_win", dec_bytes, win(64'h2010));

    // Reset in the middle of a burst
    wait_req();
    chk("mid_addr", req_addr, 64'h2040);
    req_ack = 1; tick(); req_ack = 0; tick();
    for (int i = 0; i < 3; i++) begin
      resp_cyc = 1; resp_data = beat_of(64'h2040 + 64'(i * 8)); tick();
    end
    resp_cyc = 1; reset = 0; entry = 64'h3000; tick();
    resp_cyc = 0;
    chk("mrst_req_cyc", req_cyc, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_valid", dec_valid, 0);
    chk("mrst_rip", dec_rip, 64'h3000);
    tick();
    reset = 1;
    serve(64'h3000, -1, 0);
    chk("mrst2_occ", occupancy, 64);
    chk("mrst2_win", dec_bytes, win(64'h3000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
